mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-bit 8-to-1 mux (eight_to_one_mux_16bit) between eight requesters.
- Grants one requester at a time.
- Drives the mux select lines S2..S0 and Enable.
- Enforces a maximum tenure so no requester starves the shared path.
- Sits between requesting units and the shared 16-bit bus.

---
 rtl/mux8_arb_pkg.sv | 24 ++
 rtl/mux8_rr_arbiter_if.sv | 32 +++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 38 +++
 rtl/mux8_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mux8_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mux8_arb_pkg                                               |
// | Shared types and sizes for the 8-way round-robin mux arbiter.        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package mux8_arb_pkg;

  localparam int NUM_REQ    = 8;
  localparam int IDX_W      = 3;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Requester index to its one-hot grant bit
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux8_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mux8_rr_arbiter_if                                       |
// | Request/grant and mux-select bundle between requesters and arbiter.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [NUM_REQ-1:0] Req;
  logic [NUM_REQ-1:0] Grant;
  logic               S0;
  logic               S1;
  logic               S2;
  logic               Enable;
  logic               Busy;
  logic [IDX_W-1:0]   Owner;

  // Requester side: drives requests, observes grant and mux controls
  modport master (
    output Req,
    input  Grant, S0, S1, S2, Enable, Busy, Owner
  );

  // Arbiter side
  modport slave (
    input  Req,
    output Grant, S0, S1, S2, Enable, Busy, Owner
  );

endinterface
`default_nettype wire

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_pick8                                                    |
// | Combinational rotating priority encoder: first set bit of Req&Mask   |
// | searching upward from Ptr, wrapping 7 -> 0.                          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  input  logic [NUM_REQ-1:0] Mask,
  output logic               Found,
  output logic [IDX_W-1:0]   Idx
);

  logic [NUM_REQ-1:0] w_req;

  assign w_req = Req & Mask;

  // Scan farthest-to-nearest from Ptr so the nearest candidate is written last and wins
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    Found = 1'b0;
    Idx   = '0;
    w_pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = Ptr + IDX_W'(k);
      if (w_req[w_pos]) begin
        Found = 1'b1;
        Idx   = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux8_rr_arbiter                                             |
// | Round-robin arbiter sharing one 16-bit 8:1 mux between eight         |
// | requesters, with a bounded tenure per owner.                         |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  mux8_rr_arbiter_if.slave   bus
);

  localparam logic [HOLD_CNT_W-1:0] C_CNT_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       w_owner_nxt;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       w_ptr_nxt;
  logic [HOLD_CNT_W-1:0]  r_cnt;
  logic [HOLD_CNT_W-1:0]  w_cnt_nxt;

  logic [NUM_REQ-1:0]     w_mask;
  logic                   w_found;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_own_req;
  logic                   w_at_limit;

  // r_ptr is kept at last owner + 1, so while holding it already points past the
  // owner; masking the owner out lets one picker serve idle, release and timeout.
  assign w_mask     = (r_state == HOLD) ? ~idx_to_onehot(r_owner) : {NUM_REQ{1'b1}};
  assign w_own_req  = bus.Req[r_owner];
  assign w_at_limit = (r_cnt == C_CNT_LAST);

  rr_pick8 u_pick (
    .Req   (bus.Req),
    .Ptr   (r_ptr),
    .Mask  (w_mask),
    .Found (w_found),
    .Idx   (w_idx)
  );

  // Register state, grant, owner, pointer and tenure counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: grant from idle, release/timeout handover, or keep counting tenure
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = HOLD;
          w_grant_nxt = idx_to_onehot(w_idx);
          w_owner_nxt = w_idx;
          w_ptr_nxt   = w_idx + IDX_W'(1);
          w_cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (!w_own_req || w_at_limit) begin
          if (w_found) begin
            // Handover on the same edge, no idle bubble
            w_grant_nxt = idx_to_onehot(w_idx);
            w_owner_nxt = w_idx;
            w_ptr_nxt   = w_idx + IDX_W'(1);
            w_cnt_nxt   = '0;
          end else if (!w_own_req) begin
            // Release with nobody waiting; selects keep the last owner
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
          // else: at limit but alone, keep grant with saturated counter
        end else begin
          w_cnt_nxt = r_cnt + HOLD_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign bus.Grant  = r_grant;
  assign bus.Owner  = r_owner;
  assign bus.S0     = r_owner[0];
  assign bus.S1     = r_owner[1];
  assign bus.S2     = r_owner[2];
  assign bus.Busy   = (r_state == HOLD);
  assign bus.Enable = (r_state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mux8_rr_arbiter                                          |
// | Self-checking bench: three arbiters (MAX_HOLD 1, 4, 16) on a shared  |
// | request vector, compared each cycle against a tenure-based model.    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_mux8_rr_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [7:0] req;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter_if if1 ();
  mux8_rr_arbiter_if if4 ();
  mux8_rr_arbiter_if if16 ();

  assign if1.Req  = req;
  assign if4.Req  = req;
  assign if16.Req = req;

  mux8_rr_arbiter #(.MAX_HOLD(1))  u_dut1  (.CLK(CLK), .RST_N(RST_N), .bus(if1));
  mux8_rr_arbiter #(.MAX_HOLD(4))  u_dut4  (.CLK(CLK), .RST_N(RST_N), .bus(if4));
  mux8_rr_arbiter #(.MAX_HOLD(16)) u_dut16 (.CLK(CLK), .RST_N(RST_N), .bus(if16));

  // Gather DUT outputs into arrays for uniform checking
  logic [7:0] d_grant [3];
  logic [2:0] d_owner [3];
  logic [2:0] d_sel   [3];
  logic       d_en    [3];
  logic       d_busy  [3];

  assign d_grant[0] = if1.Grant;  assign d_owner[0] = if1.Owner;
  assign d_grant[1] = if4.Grant;  assign d_owner[1] = if4.Owner;
  assign d_grant[2] = if16.Grant; assign d_owner[2] = if16.Owner;
  assign d_sel[0] = {if1.S2, if1.S1, if1.S0};
  assign d_sel[1] = {if4.S2, if4.S1, if4.S0};
  assign d_sel[2] = {if16.S2, if16.S1, if16.S0};
  assign d_en[0] = if1.Enable;  assign d_busy[0] = if1.Busy;
  assign d_en[1] = if4.Enable;  assign d_busy[1] = if4.Busy;
  assign d_en[2] = if16.Enable; assign d_busy[2] = if16.Busy;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: who owns the path, how many cycles it has held it,
  // and where the next fair search starts (one past the last owner).
  int mh   [3] = '{1, 4, 16};
  int own  [3];
  int nxt  [3];
  int ten  [3];
  bit act  [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from, input int excl);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (from + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      own[m] = 0; nxt[m] = 0; ten[m] = 0; act[m] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [7:0] r);
    for (int m = 0; m < 3; m++) begin
      int w;
      if (!act[m]) begin
        w = pick(r, nxt[m], -1);
        if (w >= 0) begin act[m] = 1'b1; own[m] = w; ten[m] = 1; end
      end else begin
        w = pick(r, (own[m] + 1) % 8, own[m]);
        if (!r[own[m]]) begin
          nxt[m] = (own[m] + 1) % 8;
          if (w >= 0) begin own[m] = w; ten[m] = 1; end
          else act[m] = 1'b0;
        end else if (ten[m] >= mh[m] && w >= 0) begin
          nxt[m] = (own[m] + 1) % 8;
          own[m] = w;
          ten[m] = 1;
        end else begin
          ten[m] = ten[m] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int m = 0; m < 3; m++) begin
      logic [7:0] eg;
      eg = act[m] ? (8'h01 << own[m]) : 8'h00;
      check($sformatf("%s_h%0d_grant", ph, mh[m]), 32'(d_grant[m]), 32'(eg));
      check($sformatf("%s_h%0d_owner", ph, mh[m]), 32'(d_owner[m]), 32'(own[m]));
      check($sformatf("%s_h%0d_sel",   ph, mh[m]), 32'(d_sel[m]),   32'(own[m]));
      check($sformatf("%s_h%0d_en",    ph, mh[m]), 32'(d_en[m]),    32'(act[m]));
      check($sformatf("%s_h%0d_busy",  ph, mh[m]), 32'(d_busy[m]),  32'(act[m]));
    end
  endtask

  // One clock: request is applied away from the edge, model and DUT advance together
  task automatic step(input logic [7:0] r, input string ph);
    req = r;
    @(posedge CLK);
    model_edge(r);
    #1;
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    RST_N = 1'b0;
    req   = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Single request, then release to idle
    step(8'h04, "single");
    check("single_grant_const", 32'(if16.Grant), 32'h04);
    check("single_sel_const", 32'({if16.S2, if16.S1, if16.S0}), 32'h2);
    step(8'h00, "drop");
    check("drop_owner_const", 32'(if16.Owner), 32'h2);

    // Full contention: MAX_HOLD=1 rotates every cycle
    for (int i = 0; i < 12; i++) step(8'hFF, "rr");
    step(8'h00, "idle");

    // Release handover without bubble: get owner 3 then release with 5 waiting
    step(8'h08, "own3");
    step(8'h28, "own3b");
    step(8'h20, "handover");
    check("handover_grant_const", 32'(if16.Grant), 32'h20);
    step(8'h00, "idle2");

    // Timeout with MAX_HOLD=4 and a lone long holder
    step(8'h01, "t_start");
    for (int i = 0; i < 6; i++) step(8'h03, "timeout");
    step(8'h00, "idle3");
    for (int i = 0; i < 20; i++) step(8'h01, "lone");
    step(8'h00, "idle4");

    // Wrap: owner 7 releases with 6 and 0 pending
    step(8'h80, "own7");
    step(8'hC1, "own7b");
    step(8'h41, "wrap");
    check("wrap_owner_const", 32'(if16.Owner), 32'h0);
    step(8'h00, "idle5");

    // Async reset mid-tenure, then recovery
    step(8'h10, "pre_rst");
    step(8'h10, "pre_rst2");
    async_reset("async_rst");
    step(8'h10, "post_rst");
    check("post_rst_grant_const", 32'(if16.Grant), 32'h10);

    // Randomized level requests with occasional reset
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      int c;
      c = int'($urandom_range(0, 15));
      if (c == 0) r = 8'($urandom);
      else if (c < 5) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
      else if (c == 5) r = 8'h00;
      else if (c == 6 && if16.Busy) r[if16.Owner] = 1'b0;
      step(r, "rand");
      if (i % 200 == 137) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
